// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: instruction fetch handshake between the fetch unit and the
// control sequencer.
//
// Handshake: the fetch unit drives instr/instr_valid; the sequencer drives
// instr_ready. One instruction transfers on every rising clock edge where
// instr_valid and instr_ready are both high. While instr_valid is high and
// instr_ready is low, the fetch unit holds instr steady. instr_ready does not
// depend on instr_valid.
//
// Signals:
//   instr        IW  instruction word (fetch -> sequencer)
//   instr_valid  1   instr is valid this cycle (fetch -> sequencer)
//   instr_ready  1   sequencer takes instr this cycle (sequencer -> fetch)
interface ctrl_seq_if #(
    parameter int IW = 9
);
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: registered control sequencer for the accumulator ISA.
// Decodes one instruction per cycle from the fetch handshake and presents
// one cycle of registered control (latency 1). LOAD with flag=1 is held for
// MEM_LAT+1 cycles to cover the data_mem read; STOP parks the sequencer in a
// sticky halt that only Reset leaves.
//
// Ports:
//   Clk, Reset    clock, synchronous active-high reset
//   fetch         instruction handshake (slave side)
//   stall         downstream hold: freezes every register, drops instr_ready
//   ctrl_valid    control outputs describe an issued instruction
//   op/flag/imm/reg_addr   registered instruction fields
//   reg_write, acc_write, reg_read, mem_to_reg, mem_read, mem_write  strobes
//   halt          sticky stop indicator
//   dbg_state     current FSM state (0 RUN, 1 MEMWAIT, 2 HALTED)
module ctrl_seq #(
    parameter int IW      = 9,
    parameter int OPW     = 4,
    parameter int FW      = IW - OPW,
    parameter int REGW    = 4,
    parameter int MEM_LAT = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    ctrl_seq_if.slave       fetch,
    input  logic            stall,
    output logic            ctrl_valid,
    output logic [OPW-1:0]  op,
    output logic            flag,
    output logic [FW-1:0]   imm,
    output logic [FW-1:0]   reg_addr,
    output logic            reg_write,
    output logic            acc_write,
    output logic            reg_read,
    output logic            mem_to_reg,
    output logic            mem_read,
    output logic            mem_write,
    output logic            halt,
    output logic [1:0]      dbg_state
);
    localparam int CW = $clog2(MEM_LAT + 1);

    localparam logic [OPW-1:0] OP_OR     = OPW'(4'b0100);
    localparam logic [OPW-1:0] OP_PARITY = OPW'(4'b1010);
    localparam logic [OPW-1:0] OP_LOAD   = OPW'(4'b1011);
    localparam logic [OPW-1:0] OP_STORE  = OPW'(4'b1100);
    localparam logic [OPW-1:0] OP_SHIFT  = OPW'(4'b1101);
    localparam logic [OPW-1:0] OP_SHIFTR = OPW'(4'b1110);
    localparam logic [OPW-1:0] OP_STOP   = OPW'(4'b1111);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_MEMWAIT = 2'd1, S_HALTED = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ctrl_valid_q, ctrl_valid_d;
    logic [OPW-1:0] op_q, op_d;
    logic           flag_q, flag_d;
    logic [FW-1:0]  imm_q, imm_d;
    logic [FW-1:0]  reg_addr_q, reg_addr_d;
    logic [5:0]     strb_q, strb_d;   // {reg_write, acc_write, reg_read, mem_to_reg, mem_read, mem_write}
    logic           halt_q, halt_d;

    logic [OPW-1:0] dec_op;
    logic           dec_flag;
    logic           accept;

    assign dec_op      = fetch.instr[IW-1 -: OPW];
    assign dec_flag    = fetch.instr[FW-1];
    assign fetch.instr_ready = (state_q == S_RUN) && !stall;
    assign accept      = fetch.instr_valid && fetch.instr_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_valid_d = ctrl_valid_q;
        op_d         = op_q;
        flag_d       = flag_q;
        imm_d        = imm_q;
        reg_addr_d   = reg_addr_q;
        strb_d       = strb_q;
        halt_d       = halt_q;

        if (!stall) begin
            unique case (state_q)
                S_RUN: begin
                    if (accept) begin
                        ctrl_valid_d = 1'b1;
                        op_d         = dec_op;
                        flag_d       = dec_flag;
                        imm_d        = fetch.instr[FW-1:0];
                        reg_addr_d   = fetch.instr[FW-1:0];
                        strb_d       = '0;
                        if (dec_op == OP_SHIFT) imm_d[FW-1] = 1'b0;
                        // Register-indexed forms use only the low REGW bits.
                        if (dec_op == OP_OR || dec_op == OP_SHIFTR ||
                            ((dec_op == OP_LOAD || dec_op == OP_STORE) && dec_flag)) begin
                            reg_addr_d             = '0;
                            reg_addr_d[REGW-1:0]   = fetch.instr[REGW-1:0];
                        end
                        if (dec_op == OP_PARITY) begin
                            reg_addr_d             = '0;
                            reg_addr_d[REGW-1:0]   = '1;
                        end
                        unique case (dec_op)
                            4'b0000, 4'b0010, 4'b0011, 4'b1101, 4'b1010:
                                strb_d = 6'b010000;
                            4'b0001, 4'b0100, 4'b0101, 4'b0111, 4'b1110:
                                strb_d = 6'b011000;
                            4'b1011: begin
                                if (dec_flag) begin
                                    // Memory read phase; acc_write comes at the end.
                                    strb_d  = 6'b001010;
                                    cnt_d   = CW'(MEM_LAT);
                                    state_d = S_MEMWAIT;
                                end else begin
                                    strb_d = 6'b011000;
                                end
                            end
                            4'b1100: strb_d = dec_flag ? 6'b001001 : 6'b100000;
                            4'b1111: begin
                                halt_d  = 1'b1;
                                state_d = S_HALTED;
                            end
                            default: strb_d = '0;
                        endcase
                    end else begin
                        ctrl_valid_d = 1'b0;
                        strb_d       = '0;
                    end
                end
                S_MEMWAIT: begin
                    // cnt counts remaining read cycles; 1 -> enter the retire
                    // cycle, 0 -> retire cycle done, back to RUN.
                    if (cnt_q == CW'(1)) begin
                        strb_d = 6'b011110;
                        cnt_d  = '0;
                    end else if (cnt_q == '0) begin
                        ctrl_valid_d = 1'b0;
                        strb_d       = '0;
                        state_d      = S_RUN;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_HALTED: begin
                    ctrl_valid_d = 1'b0;
                    strb_d       = '0;
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_RUN;
            cnt_q        <= '0;
            ctrl_valid_q <= 1'b0;
            op_q         <= '0;
            flag_q       <= 1'b0;
            imm_q        <= '0;
            reg_addr_q   <= '0;
            strb_q       <= '0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_valid_q <= ctrl_valid_d;
            op_q         <= op_d;
            flag_q       <= flag_d;
            imm_q        <= imm_d;
            reg_addr_q   <= reg_addr_d;
            strb_q       <= strb_d;
            halt_q       <= halt_d;
        end
    end

    assign ctrl_valid = ctrl_valid_q;
    assign op         = op_q;
    assign flag       = flag_q;
    assign imm        = imm_q;
    assign reg_addr   = reg_addr_q;
    assign reg_write  = strb_q[5];
    assign acc_write  = strb_q[4];
    assign reg_read   = strb_q[3];
    assign mem_to_reg = strb_q[2];
    assign mem_read   = strb_q[1];
    assign mem_write  = strb_q[0];
    assign halt       = halt_q;
    assign dbg_state  = state_q;
endmodule
